// File: rtl/datapath_controller.sv
// Sequencer for the 8-register bus datapath: fetch, wait, decode, then 1 or 3 execute steps.
// Optional build macro DATAPATH_CONTROLLER_SINGLE_STEP_EN adds a `step` input and a HOLD state.
module datapath_controller #(
  parameter int          FETCH_WAIT = 1,
  parameter logic [15:0] IDLE_ROUT  = 16'h8000
) (
  input  logic        clock,
  input  logic        resetnot,
`ifdef DATAPATH_CONTROLLER_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [7:0]  instruction,
  output logic [15:0] rout,
  output logic [15:0] ren,
  output logic        addxor,
  output logic        increment,
  output logic        done
);

  typedef enum logic [2:0] {
    S_FETCH, S_WAIT, S_DECODE, S_EXEC1, S_EXEC2, S_EXEC3
`ifdef DATAPATH_CONTROLLER_SINGLE_STEP_EN
    , S_HOLD
`endif
  } state_t;

`ifdef DATAPATH_CONTROLLER_SINGLE_STEP_EN
  localparam state_t RESET_STATE = S_HOLD;
  localparam state_t DONE_NEXT   = S_HOLD;
`else
  localparam state_t RESET_STATE = S_FETCH;
  localparam state_t DONE_NEXT   = S_FETCH;
`endif

  localparam logic [15:0] SEL_G      = 16'h0100;
  localparam logic [15:0] SEL_A      = 16'h0200;
  localparam logic [15:0] SEL_EXTERN = 16'h0400;
  localparam logic [2:0]  WAIT_LAST  = 3'(FETCH_WAIT - 1);

  state_t     state;
  logic [7:0] ir;
  logic [2:0] wait_cnt;
  logic [2:0] rx, ry;

  assign rx = ir[5:3];
  assign ry = ir[2:0];

  function automatic logic [15:0] onehot(input logic [2:0] idx);
    return 16'h0001 << idx;
  endfunction

  // The state names the step issued at the next edge; outputs for that step
  // are registered on the same edge, so each step is visible for one cycle.
  always_ff @(posedge clock or negedge resetnot) begin
    if (!resetnot) begin
      state     <= RESET_STATE;
      ir        <= '0;
      wait_cnt  <= '0;
      rout      <= IDLE_ROUT;
      ren       <= '0;
      addxor    <= 1'b0;
      increment <= 1'b0;
      done      <= 1'b0;
    end else begin
      rout      <= IDLE_ROUT;
      ren       <= '0;
      addxor    <= 1'b0;
      increment <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_FETCH: begin
          increment <= 1'b1;
          wait_cnt  <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_DECODE;
          else                       wait_cnt <= wait_cnt + 3'd1;
        end
        S_DECODE: begin
          ir    <= instruction;
          state <= S_EXEC1;
        end
        S_EXEC1: begin
          case (ir[7:6])
            2'b00: begin
              rout  <= onehot(ry);
              ren   <= onehot(rx);
              done  <= 1'b1;
              state <= DONE_NEXT;
            end
            2'b01: begin
              rout   <= SEL_EXTERN;
              ren    <= onehot(rx);
              addxor <= 1'b1;
              done   <= 1'b1;
              state  <= DONE_NEXT;
            end
            default: begin
              rout  <= onehot(rx);
              ren   <= SEL_A;
              state <= S_EXEC2;
            end
          endcase
        end
        S_EXEC2: begin
          rout   <= onehot(ry);
          ren    <= SEL_G;
          addxor <= ir[6];  // op 11 is XOR
          state  <= S_EXEC3;
        end
        S_EXEC3: begin
          rout  <= SEL_G;
          ren   <= onehot(rx);
          done  <= 1'b1;
          state <= DONE_NEXT;
        end
`ifdef DATAPATH_CONTROLLER_SINGLE_STEP_EN
        S_HOLD: begin
          if (step) state <= S_FETCH;
        end
`endif
        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Directed, table-driven bench for datapath_controller (FETCH_WAIT=1).
module tb_datapath_controller;

  logic        clock = 1'b0;
  logic        resetnot;
  logic        step;
  logic [7:0]  instruction;
  logic [15:0] rout, ren;
  logic        addxor, increment, done;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  datapath_controller #(.FETCH_WAIT(1), .IDLE_ROUT(16'h8000)) dut (
    .clock       (clock),
    .resetnot    (resetnot),
`ifdef DATAPATH_CONTROLLER_SINGLE_STEP_EN
    .step        (step),
`endif
    .instruction (instruction),
    .rout        (rout),
    .ren         (ren),
    .addxor      (addxor),
    .increment   (increment),
    .done        (done)
  );

  typedef struct {
    logic [7:0]       ins;
    int               n;
    logic [2:0][15:0] ro;
    logic [2:0][15:0] re;
    logic [2:0]       ax;
    logic [2:0]       dn;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_incr();
    int cnt = 0;
    while (increment !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("fetch_increment", 16'(increment), 16'h1);
  endtask

  initial begin
    // {ins, steps, rout[2:0], ren[2:0], addxor[2:0], done[2:0]}; index 0 = EXEC1
    vecs[0] = '{8'h41, 1, {16'h0, 16'h0, 16'h0400}, {16'h0, 16'h0, 16'h0001}, 3'b001, 3'b001};
    vecs[1] = '{8'h81, 3, {16'h0100, 16'h0002, 16'h0001}, {16'h0001, 16'h0100, 16'h0200}, 3'b000, 3'b100};
    vecs[2] = '{8'hD3, 3, {16'h0100, 16'h0008, 16'h0004}, {16'h0004, 16'h0100, 16'h0200}, 3'b010, 3'b100};
    vecs[3] = '{8'h00, 1, {16'h0, 16'h0, 16'h0001}, {16'h0, 16'h0, 16'h0001}, 3'b000, 3'b001};
    vecs[4] = '{8'h3E, 1, {16'h0, 16'h0, 16'h0040}, {16'h0, 16'h0, 16'h0080}, 3'b000, 3'b001};
    vecs[5] = '{8'h6D, 1, {16'h0, 16'h0, 16'h0400}, {16'h0, 16'h0, 16'h0020}, 3'b001, 3'b001};
    vecs[6] = '{8'hBF, 3, {16'h0100, 16'h0080, 16'h0080}, {16'h0080, 16'h0100, 16'h0200}, 3'b000, 3'b100};
    vecs[7] = '{8'hC8, 3, {16'h0100, 16'h0001, 16'h0002}, {16'h0002, 16'h0100, 16'h0200}, 3'b010, 3'b100};

    resetnot    = 1'b0;
    step        = 1'b0;
    instruction = 8'h00;
    #12;
    chk("reset_rout", rout, 16'h8000);
    chk("reset_ren", ren, 16'h0000);
    chk("reset_increment", 16'(increment), 16'h0);
    chk("reset_done", 16'(done), 16'h0);
    chk("reset_addxor", 16'(addxor), 16'h0);
    #1 resetnot = 1'b1;
    tick();
`ifdef DATAPATH_CONTROLLER_SINGLE_STEP_EN
    chk("hold_no_increment", 16'(increment), 16'h0);
    tick();
    chk("hold_no_increment2", 16'(increment), 16'h0);
    step = 1'b1;
    tick();
    tick();
`endif
    chk("first_cycle_increment", 16'(increment), 16'h1);

    for (int v = 0; v < 8; v++) begin
      wait_incr();
      instruction = vecs[v].ins;
      tick();
      chk("wait_increment", 16'(increment), 16'h0);
      chk("wait_rout", rout, 16'h8000);
      chk("wait_ren", ren, 16'h0000);
      tick();
      chk("decode_rout", rout, 16'h8000);
      chk("decode_ren", ren, 16'h0000);
      chk("decode_done", 16'(done), 16'h0);
      instruction = ~vecs[v].ins;  // IR already holds the opcode
      for (int k = 0; k < vecs[v].n; k++) begin
        tick();
        chk($sformatf("v%0d_e%0d_rout", v, k + 1), rout, vecs[v].ro[k]);
        chk($sformatf("v%0d_e%0d_ren", v, k + 1), ren, vecs[v].re[k]);
        chk($sformatf("v%0d_e%0d_addxor", v, k + 1), 16'(addxor), 16'(vecs[v].ax[k]));
        chk($sformatf("v%0d_e%0d_done", v, k + 1), 16'(done), 16'(vecs[v].dn[k]));
      end
      tick();
      chk("post_ren", ren, 16'h0000);
      chk("post_addxor", 16'(addxor), 16'h0);
      chk("post_done", 16'(done), 16'h0);
      chk("post_rout", rout, 16'h8000);
`ifndef DATAPATH_CONTROLLER_SINGLE_STEP_EN
      chk($sformatf("v%0d_latency_increment", v), 16'(increment), 16'h1);
`endif
    end

    // Reset in the middle of ADD EXEC2
    wait_incr();
    instruction = 8'h81;
    tick();
    tick();
    tick();
    tick();
    chk("pre_reset_exec2_rout", rout, 16'h0002);
    #2 resetnot = 1'b0;
    #1;
    chk("async_reset_rout", rout, 16'h8000);
    chk("async_reset_ren", ren, 16'h0000);
    chk("async_reset_done", 16'(done), 16'h0);
    step = 1'b0;
    tick();
    chk("held_reset_rout", rout, 16'h8000);
    #2 resetnot = 1'b1;
    tick();
`ifdef DATAPATH_CONTROLLER_SINGLE_STEP_EN
    chk("post_reset_hold", 16'(increment), 16'h0);
    step = 1'b1;
    tick();
    tick();
`endif
    chk("post_reset_increment", 16'(increment), 16'h1);
    tick();
    chk("post_reset_pulse_end", 16'(increment), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
